// File: rtl/sd_pkg.sv
// Shared definitions for the self-destruct sequencer.
//   sd_state_t : encoded FSM states (also driven out on the debug state port)
//   LED_ALL_ON : all-ones pattern, sliced to the LED width by users
//   sd_clog2   : ceiling log2 used to size the tick counter
package sd_pkg;

  typedef enum logic [2:0] {
    SAFE      = 3'd0,
    PENDING   = 3'd1,
    COUNTDOWN = 3'd2,
    HOLD      = 3'd3,
    DETONATED = 3'd4
  } sd_state_t;

  localparam logic [63:0] LED_ALL_ON = '1;

  function automatic int sd_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sd_tick_timer.sv
// Tick-gated counter shared by every timed state of the sequencer.
//   clk, reset : clock and synchronous active-low reset
//   tick       : count enable strobe
//   clr        : synchronous clear (asserted on each state change)
//   term       : terminal count; tc fires on the tick that completes it
//   count      : current tick count
//   tc         : combinational terminal-count strobe (tick && count == term-1)
module sd_tick_timer #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          clr,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = tick && (count == (term - CW'(1)));

  // Wrapping on terminal count lets COUNTDOWN reuse the timer step after step
  // without a state change in between.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/selfdestruct_sequencer.sv
// Self-destruct countdown controller: arming, confirmation, countdown,
// hold, abort and a latched detonate flag.
//   clk, reset : clock and synchronous active-low reset
//   tick       : one-clk 10 ms timebase strobe
//   threat     : registered danger vote (level)
//   in_combat  : combat switch (level); low forces SAFE
//   confirm    : operator confirm pulse
//   abort_req  : operator abort pulse
//   leds       : countdown pattern (registered)
//   blink_en   : high in PENDING and HOLD (registered)
//   state      : encoded FSM state for debug (registered)
//   busy       : high except in SAFE and DETONATED (registered)
//   detonate   : sticky, high only in DETONATED (registered)
module selfdestruct_sequencer
  import sd_pkg::*;
#(
  parameter int STEP_TICKS    = 100,
  parameter int CONFIRM_TICKS = 500,
  parameter int HOLD_TICKS    = 300,
  parameter int LED_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             threat,
  input  logic             in_combat,
  input  logic             confirm,
  input  logic             abort_req,
  output logic [LED_W-1:0] leds,
  output logic             blink_en,
  output logic [2:0]       state,
  output logic             busy,
  output logic             detonate
);

  localparam int MAX_A = (STEP_TICKS > CONFIRM_TICKS) ? STEP_TICKS : CONFIRM_TICKS;
  localparam int MAX_T = (MAX_A > HOLD_TICKS) ? MAX_A : HOLD_TICKS;
  localparam int CW    = sd_clog2(MAX_T) + 1;
  localparam logic [LED_W-1:0] ALL_ON = LED_ALL_ON[LED_W-1:0];

  sd_state_t        state_q, state_next;
  logic [LED_W-1:0] leds_q, leds_next, leds_shift;
  logic             blink_next, busy_next, detonate_next;
  logic [CW-1:0]    term, tick_cnt;
  logic             tc, timer_clr;

  // A wide confirm/abort pulse is honoured once: the used flag is set when
  // the pulse is acted on and cleared only after the input returns low.
  logic confirm_used, abort_used;
  logic confirm_ev, abort_ev, confirm_take, abort_take;

  assign confirm_ev = confirm && !confirm_used;
  assign abort_ev   = abort_req && !abort_used;
  assign leds_shift = leds_q >> 1;

  always_comb begin
    term = CW'(1);
    case (state_q)
      PENDING:   term = CW'(CONFIRM_TICKS);
      COUNTDOWN: term = CW'(STEP_TICKS);
      HOLD:      term = CW'(HOLD_TICKS);
      default:   term = CW'(1);
    endcase
  end

  sd_tick_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clr   (timer_clr),
    .term  (term),
    .count (tick_cnt),
    .tc    (tc)
  );

  assign timer_clr = (state_next != state_q);

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= SAFE;
      leds_q       <= ALL_ON;
      blink_en     <= 1'b0;
      busy         <= 1'b0;
      detonate     <= 1'b0;
      confirm_used <= 1'b0;
      abort_used   <= 1'b0;
    end else begin
      state_q      <= state_next;
      leds_q       <= leds_next;
      blink_en     <= blink_next;
      busy         <= busy_next;
      detonate     <= detonate_next;
      confirm_used <= confirm && (confirm_used || confirm_take);
      abort_used   <= abort_req && (abort_used || abort_take);
    end
  end

  // Next-state and LED shift logic
  always_comb begin
    state_next   = state_q;
    leds_next    = leds_q;
    confirm_take = 1'b0;
    abort_take   = 1'b0;
    if (state_q == DETONATED) begin
      state_next = DETONATED;
    end else if (!in_combat) begin
      state_next = SAFE;
    end else if (abort_ev && (state_q != SAFE)) begin
      state_next = SAFE;
      abort_take = 1'b1;
    end else begin
      case (state_q)
        SAFE: begin
          if (threat) state_next = PENDING;
        end
        PENDING: begin
          if (confirm_ev) begin
            state_next   = COUNTDOWN;
            confirm_take = 1'b1;
          end else if (!threat || tc) begin
            state_next = SAFE;
          end
        end
        COUNTDOWN: begin
          // A step on the same edge as threat falling is taken before HOLD.
          if (tc) leds_next = leds_shift;
          if (tc && (leds_shift == '0)) state_next = DETONATED;
          else if (!threat)             state_next = HOLD;
        end
        HOLD: begin
          if (threat)  state_next = COUNTDOWN;
          else if (tc) state_next = SAFE;
        end
        default: state_next = SAFE;
      endcase
    end
    if (state_next == SAFE)      leds_next = ALL_ON;
    if (state_next == DETONATED) leds_next = '0;
  end

  // Output decode from the next state so outputs change with the transition
  always_comb begin
    blink_next    = (state_next == PENDING) || (state_next == HOLD);
    busy_next     = (state_next != SAFE) && (state_next != DETONATED);
    detonate_next = (state_next == DETONATED);
  end

  assign leds  = leds_q;
  assign state = state_q;

endmodule

// File: tb/tb_selfdestruct_sequencer.sv
module tb_selfdestruct_sequencer;

  localparam int LED_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick, threat, in_combat, confirm, abort_req;
  logic [LED_W-1:0] leds;
  logic             blink_en, busy, detonate;
  logic [2:0]       state;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] S_SAFE = 3'd0, S_PEND = 3'd1, S_CD = 3'd2,
                         S_HOLD = 3'd3, S_DET = 3'd4;

  selfdestruct_sequencer #(
    .STEP_TICKS    (4),
    .CONFIRM_TICKS (6),
    .HOLD_TICKS    (5),
    .LED_W         (LED_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .threat    (threat),
    .in_combat (in_combat),
    .confirm   (confirm),
    .abort_req (abort_req),
    .leds      (leds),
    .blink_en  (blink_en),
    .state     (state),
    .busy      (busy),
    .detonate  (detonate)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Two idle edges, then one edge with tick high (tick every 3 clk).
  // threat and confirm take the given values on the tick edge.
  task automatic tk_with(input logic thr, input logic conf);
    cyc();
    cyc();
    tick    = 1'b1;
    threat  = thr;
    confirm = conf;
    cyc();
    tick    = 1'b0;
    confirm = 1'b0;
  endtask

  task automatic tk();
    tk_with(threat, 1'b0);
  endtask

  task automatic tks(input int n);
    for (int i = 0; i < n; i++) tk();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic arm_and_confirm();
    threat = 1'b1;
    cyc();
    confirm = 1'b1;
    cyc();
    confirm = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; threat = 1'b0; in_combat = 1'b1;
    confirm = 1'b0; abort_req = 1'b0;
    cyc();
    cyc();
    check_eq("rst_state", state, S_SAFE);
    check_eq("rst_leds", leds, 8'hFF);
    check_eq("rst_flags", {blink_en, busy, detonate}, 3'b000);
    reset = 1'b1;

    // Full countdown: confirm two ticks into PENDING, eight steps to detonate
    threat = 1'b1;
    cyc();
    check_eq("pend_state", state, S_PEND);
    check_eq("pend_flags", {blink_en, busy, detonate}, 3'b110);
    tks(2);
    confirm = 1'b1;
    cyc();
    confirm = 1'b0;
    check_eq("cd_state", state, S_CD);
    check_eq("cd_flags", {blink_en, busy, detonate}, 3'b010);
    for (int s = 1; s <= 8; s++) begin
      tks(3);
      check_eq("cd_prestep", leds, 8'hFF >> (s - 1));
      tk();
      check_eq("cd_step", leds, 8'hFF >> s);
    end
    check_eq("det_state", state, S_DET);
    check_eq("det_flags", {blink_en, busy, detonate}, 3'b001);
    threat = 1'b0;
    in_combat = 1'b0;
    abort_req = 1'b1;
    cyc();
    abort_req = 1'b0;
    tks(3);
    check_eq("det_sticky", {state, leds, detonate}, {S_DET, 8'h00, 1'b1});
    in_combat = 1'b1;

    // Reset mid-countdown at leds 0x1F
    do_reset();
    arm_and_confirm();
    tks(12);
    check_eq("mid_leds", leds, 8'h1F);
    tk_with(1'b1, 1'b0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check_eq("midrst_state", state, S_SAFE);
    check_eq("midrst_leds", leds, 8'hFF);
    check_eq("midrst_det", detonate, 1'b0);
    check_eq("midrst_cnt", dut.tick_cnt, 0);

    // PENDING timeout after 6 ticks, and threat loss returns to SAFE
    threat = 1'b1;
    cyc();
    tks(5);
    check_eq("to_before", state, S_PEND);
    tk();
    threat = 1'b0;
    check_eq("to_safe", state, S_SAFE);
    check_eq("to_blink", blink_en, 1'b0);
    threat = 1'b1;
    cyc();
    tks(3);
    threat = 1'b0;
    cyc();
    check_eq("drop_safe", {state, blink_en}, {S_SAFE, 1'b0});

    // HOLD: freeze at 0x3F, partial step discarded, resume after 2 ticks
    arm_and_confirm();
    tks(8);
    check_eq("hold_pre", leds, 8'h3F);
    tks(2);
    threat = 1'b0;
    cyc();
    check_eq("hold_state", {state, blink_en, busy}, {S_HOLD, 1'b1, 1'b1});
    check_eq("hold_leds", leds, 8'h3F);
    tks(2);
    threat = 1'b1;
    cyc();
    check_eq("resume_state", {state, leds}, {S_CD, 8'h3F});
    tks(3);
    check_eq("resume_nostep", leds, 8'h3F);
    tk();
    check_eq("resume_step", leds, 8'h1F);
    threat = 1'b0;
    cyc();
    tks(4);
    check_eq("hold_4", state, S_HOLD);
    tk();
    check_eq("hold_to", {state, leds}, {S_SAFE, 8'hFF});

    // Aborts in PENDING, COUNTDOWN (0x0F) and HOLD
    threat = 1'b1;
    cyc();
    abort_req = 1'b1;
    cyc();
    abort_req = 1'b0;
    check_eq("abort_pend", state, S_SAFE);
    cyc();
    confirm = 1'b1;
    cyc();
    confirm = 1'b0;
    tks(16);
    check_eq("abort_cd_pre", leds, 8'h0F);
    abort_req = 1'b1;
    cyc();
    abort_req = 1'b0;
    check_eq("abort_cd", {state, leds}, {S_SAFE, 8'hFF});
    arm_and_confirm();
    threat = 1'b0;
    cyc();
    check_eq("abort_hold_pre", state, S_HOLD);
    abort_req = 1'b1;
    cyc();
    abort_req = 1'b0;
    check_eq("abort_hold", state, S_SAFE);

    // Wide pulses act once
    threat = 1'b1;
    confirm = 1'b1;
    cyc();
    check_eq("wide_safe_ign", state, S_PEND);
    cyc();
    check_eq("wide_conf", state, S_CD);
    abort_req = 1'b1;
    cyc();
    check_eq("wide_abort", state, S_SAFE);
    cyc();
    abort_req = 1'b0;
    cyc();
    check_eq("wide_conf_once", state, S_PEND);
    confirm = 1'b0;
    cyc();
    confirm = 1'b1;
    cyc();
    confirm = 1'b0;
    check_eq("new_conf", state, S_CD);

    // Simultaneous events
    abort_req = 1'b1;
    cyc();
    abort_req = 1'b0;
    cyc();
    in_combat = 1'b0;
    confirm = 1'b1;
    cyc();
    confirm = 1'b0;
    in_combat = 1'b1;
    check_eq("combat_wins", state, S_SAFE);
    cyc();
    check_eq("rearm", state, S_PEND);
    tks(5);
    tk_with(1'b1, 1'b1);
    check_eq("conf_on_to", state, S_CD);
    tks(3);
    tk_with(1'b0, 1'b0);
    check_eq("step_then_hold", {state, leds}, {S_HOLD, 8'h7F});
    threat = 1'b1;
    cyc();
    tks(24);
    check_eq("final_pre", {state, leds}, {S_CD, 8'h01});
    tks(3);
    tk_with(1'b0, 1'b0);
    check_eq("final_det", {state, leds, detonate}, {S_DET, 8'h00, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/selfdestruct_sequencer.md
Name: selfdestruct_sequencer

Overview:
- Central controller for the self-destruct countdown path. Sits between the debounced switch and threat-vote logic and the LED blink stage.
- Sequences arming, operator confirmation, countdown, hold and abort.
- Drives the 8-bit LED pattern, the blink enable and a latched detonate flag.
- Replaces free-running countdown control with an explicit FSM and an explicit handshake.

Parameters:
- STEP_TICKS, 100: ticks per countdown step (one LED extinguished per step).
- CONFIRM_TICKS, 500: ticks allowed in PENDING for confirm before auto-return to SAFE.
- HOLD_TICKS, 300: ticks a HOLD may last before falling back to SAFE.
- LED_W, 8: LED pattern width; countdown takes LED_W steps.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- tick  in  1  one-clk strobe from the 10 ms timebase; all timing counts ticks
- threat  in  1  registered 2-of-3 danger vote (level)
- in_combat  in  1  debounced combat switch (level); low forces SAFE
- confirm  in  1  one-clk operator confirm pulse
- abort_req  in  1  one-clk operator abort pulse
- leds  out  LED_W  countdown pattern
- blink_en  out  1  high in PENDING and HOLD; enables the blink stage
- state  out  3  encoded FSM state for debug
- busy  out  1  high in any state except SAFE and DETONATED
- detonate  out  1  sticky; high only in DETONATED

Behaviour:
- Clock and reset: reset is "reset reset, synchronous, active-low; clock clk". Reset is sampled at a clk edge only.
- Reset values:
  - state = SAFE
  - leds = all ones
  - tick_cnt = 0
  - blink_en = 0
  - busy = 0
  - detonate = 0
- Outputs: all registered; each is updated on the same edge as the state transition that causes it.
- Tick counter: tick_cnt, width clog2(max parameter)+1.
  - Increments only on cycles with tick=1.
  - Clears to 0 on every state change.
- Priority each edge, highest first:
  1. reset low
  2. state DETONATED (stays; nothing else honoured)
  3. in_combat low -> SAFE
  4. abort_req -> SAFE, legal in PENDING, COUNTDOWN and HOLD
  5. state-specific rules below
- Entering SAFE by any path sets leds to all ones.
- SAFE: threat=1 and in_combat=1 -> PENDING. confirm is ignored in SAFE.
- PENDING:
  - confirm -> COUNTDOWN.
  - threat=0 -> SAFE.
  - On a tick with tick_cnt reaching CONFIRM_TICKS-1 -> SAFE (timeout).
  - confirm and timeout on the same cycle: confirm wins.
- COUNTDOWN:
  - On a tick with tick_cnt = STEP_TICKS-1: leds <= leds >> 1 and tick_cnt <= 0.
  - If the shifted value is 0, the same edge moves to DETONATED with leds = 0 and detonate = 1.
  - threat=0 -> HOLD. leds freeze and the partial step count is discarded.
  - threat falling on the same cycle as a step tick: the step is taken first, then HOLD is entered. If that step reaches 0, DETONATED wins.
- HOLD:
  - threat=1 -> COUNTDOWN, leds retained, tick_cnt = 0.
  - On a tick with tick_cnt reaching HOLD_TICKS-1 -> SAFE.
  - confirm is ignored.
- DETONATED: leds = 0 and detonate = 1 until reset.
- Total countdown with no hold: LED_W*STEP_TICKS ticks from the confirm edge.
- Pulse width: confirm and abort_req wider than 1 clk are acted on only in the first cycle they are sampled in a state where they are legal. A wider pulse therefore acts as a single event.
- tick is never assumed coincident with any other input; all combinations are legal.

Decomposition:
- Shared package sd_pkg holds:
  - state enum: SAFE=0, PENDING=1, COUNTDOWN=2, HOLD=3, DETONATED=4
  - LED_ALL_ON constant
  - clog2 helper
- One natural sub-module: sd_tick_timer. It is a tick-gated counter with clear and terminal-count compare; one instance is shared by all timed states and reloaded on every state change.
- The FSM and the LED shift register stay in the top module.

Test Plan:
Bench uses STEP_TICKS=4, CONFIRM_TICKS=6, HOLD_TICKS=5, tick every 3 clk.
1. Reset low mid-COUNTDOWN with leds=0x1F -> next edge: state=SAFE, leds=0xFF, detonate=0, tick_cnt=0.
2. threat=1, confirm 2 ticks later, no further events -> leds steps 0xFF, 0x7F ... 0x01 every 4 ticks. On the 8th step, leds=0x00 and detonate=1 on the same edge, 32 ticks after confirm. Detonate holds until reset.
3. threat=1 with no confirm -> PENDING with blink_en=1; SAFE after 6 ticks. threat=0 at tick 3 instead -> SAFE immediately.
4. threat drops at leds=0x3F -> HOLD with leds frozen at 0x3F. threat returns after 2 ticks -> resumes and the next step comes 4 ticks later. A separate run holds 5 ticks -> SAFE with leds=0xFF.
5. abort_req in PENDING, in COUNTDOWN at leds=0x0F and in HOLD -> SAFE next edge. abort_req after detonate -> no effect.
6. Simultaneous events: in_combat low with confirm -> SAFE; confirm on the timeout tick -> COUNTDOWN; threat falling on the final step tick -> DETONATED.
